// File: rtl/ysyx_22041071_imem_rsp_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_imem_rsp_pkg : shared bus defines, response entry type, address helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef YSYX_22041071_DEFINE_V
`define YSYX_22041071_DEFINE_V
`define ysyx_22041071_ADDR_BUS 63:0
`define ysyx_22041071_INS_BUS 31:0
`define START_ADDR 64'h0000_0000_8000_0000
`endif

package ysyx_22041071_imem_rsp_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INS_W  = 32;
  localparam logic [ADDR_W-1:0] START_ADDR = `START_ADDR;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
    logic              err;
  } rsp_entry_t;

  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr < START_ADDR);
  endfunction

  // Faulting addresses never reach the memory: their index is pinned to 0.
  function automatic logic [63:0] mem_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - START_ADDR;
    return addr_err(addr) ? 64'd0 : {3'b000, off[ADDR_W-1:3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/RAMHelper.sv
// ---------------------------------------------------------------------------
// RAMHelper : combinational-read doubleword memory with a fixed content pattern
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module RAMHelper (
  input  logic        en,
  input  logic [63:0] rIdx,
  output logic [63:0] rdata,
  input  logic [63:0] wIdx,
  input  logic [63:0] wdata,
  input  logic [63:0] wmask,
  input  logic        wen
);

  logic [31:0] fold;
  logic [63:0] base;

  assign fold = rIdx[31:0] ^ rIdx[63:32];
  assign base = {fold * 32'h85EB_CA6B ^ 32'h2468_ACE0,
                 fold * 32'h9E37_79B9 ^ 32'h1357_9BDF};

  // A same-index write is visible immediately through the read port.
  always_comb begin
    rdata = 64'd0;
    if (en) begin
      rdata = base;
      if (wen && (wIdx == rIdx)) begin
        rdata = (base & ~wmask) | (wdata & wmask);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22041071_RSP_FIFO.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_RSP_FIFO : DEPTH-entry response FIFO with synchronous flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_22041071_RSP_FIFO
  import ysyx_22041071_imem_rsp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int FIFO_AW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  rsp_entry_t         push_data,
  input  logic               pop,
  output rsp_entry_t         head_data,
  output logic [FIFO_AW:0]   count
);

  rsp_entry_t         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q + FIFO_AW'(push);
    rptr_d  = rptr_q + FIFO_AW'(pop);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22041071_imem_rsp.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_imem_rsp : instruction fetch responder (stage register + response FIFO)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_22041071_imem_rsp
  import ysyx_22041071_imem_rsp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int FIFO_AW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [`ysyx_22041071_ADDR_BUS] req_addr,
  input  logic                          flush,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [`ysyx_22041071_ADDR_BUS] resp_pc,
  output logic [`ysyx_22041071_INS_BUS]  resp_ins,
  output logic                          resp_err
);

  localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW + 2)'(DEPTH);

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [FIFO_AW:0]  fifo_count;
  logic [FIFO_AW+1:0] occupancy;
  logic              req_fire, resp_fire;
  logic              stage_err;
  logic [63:0]       ram_idx, ram_rdata;
  rsp_entry_t        push_entry, head_entry;

  // The stage slot counts toward capacity so an accepted request always has a FIFO seat.
  assign occupancy = {1'b0, fifo_count} + {{(FIFO_AW + 1){1'b0}}, inflight_q};
  assign req_ready = !flush && (occupancy < DEPTH_W);
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  always_comb begin
    inflight_d   = req_fire;
    stage_addr_d = req_fire ? req_addr : stage_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    stage_addr_q <= stage_addr_d;
  end

  assign stage_err = addr_err(stage_addr_q);
  assign ram_idx   = mem_index(stage_addr_q);

  RAMHelper u_ram (
    .en    (1'b1),
    .rIdx  (ram_idx),
    .rdata (ram_rdata),
    .wIdx  (64'd0),
    .wdata (64'd0),
    .wmask (64'd0),
    .wen   (1'b0)
  );

  always_comb begin
    push_entry     = '0;
    push_entry.pc  = stage_addr_q;
    push_entry.err = stage_err;
    if (!stage_err) begin
      push_entry.ins = stage_addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0];
    end
  end

  ysyx_22041071_RSP_FIFO #(
    .DEPTH   (DEPTH),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (resp_fire),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign resp_valid = (fifo_count != '0);
  assign resp_pc    = head_entry.pc;
  assign resp_ins   = head_entry.ins;
  assign resp_err   = head_entry.err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041071_imem_rsp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_imem_rsp : scoreboard bench for the fetch responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_22041071_imem_rsp;

  localparam int DEPTH   = 2;
  localparam int FIFO_AW = 1;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_pc;
  logic [31:0] resp_ins;
  logic        resp_err;

  always #5 clk = ~clk;

  ysyx_22041071_imem_rsp #(.DEPTH(DEPTH), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pc    (resp_pc),
    .resp_ins   (resp_ins),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_ready = 1'b0;

  // Memory contents as a function of doubleword index, then the fetch rules on top.
  function automatic exp_t model(input logic [63:0] a, input int due);
    exp_t        e;
    logic [63:0] idx;
    logic [31:0] k;
    e.pc  = a;
    e.due = due;
    e.err = (a % 4 != 0) || (a < BASE);
    e.ins = 32'h0;
    if (!e.err) begin
      idx = (a - BASE) / 8;
      k   = idx[31:0] ^ idx[63:32];
      e.ins = ((a / 4) % 2 == 1) ? (k * 32'h85EB_CA6B ^ 32'h2468_ACE0)
                                 : (k * 32'h9E37_79B9 ^ 32'h1357_9BDF);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares handshake and head data, pops on a consumed response.
  always @(negedge clk) begin
    bit exp_valid;
    if (!reset) begin
      exp_ready = !flush && (sb.size() < DEPTH);
      check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
      exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
      check("resp_valid", {63'd0, resp_valid}, {63'd0, exp_valid});
      if (resp_valid && exp_valid) begin
        check("resp_pc", resp_pc, sb[0].pc);
        check("resp_ins", {32'd0, resp_ins}, {32'd0, sb[0].ins});
        check("resp_err", {63'd0, resp_err}, {63'd0, sb[0].err});
        if (resp_ready) void'(sb.pop_front());
      end
    end else begin
      exp_ready = 1'b0;
    end
  end

  task automatic step(input bit v, input logic [63:0] a, input bit rr, input bit fl, input bit rs);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    flush      = fl;
    reset      = rs;
    @(posedge clk);
    if (rs || fl) sb.delete();
    else if (v && exp_ready) sb.push_back(model(a, cyc + 2));
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return BASE + 64'(4 * $urandom_range(0, 63));
    if (r == 7) return BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
    if (r == 8) return BASE - 64'(4 * $urandom_range(1, 64));
    return 64'h1_0000_0000 + 64'(8 * $urandom_range(0, 15));
  endfunction

  initial begin
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    idle(1);

    step(1'b1, BASE, 1'b1, 1'b0, 1'b0);
    idle(3);

    step(1'b1, BASE,        1'b1, 1'b0, 1'b0);
    step(1'b1, BASE + 64'h4, 1'b1, 1'b0, 1'b0);
    step(1'b1, BASE + 64'h8, 1'b1, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 5; i++) step(1'b1, BASE + 64'(8 * i + 16), 1'b0, 1'b0, 1'b0);
    idle(4);

    step(1'b1, BASE + 64'h2,     1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h7FFF_FFFC,    1'b1, 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 4; i++) step(1'b1, BASE + 64'(4 * i + 40), 1'b0, 1'b0, 1'b0);
    step(1'b1, BASE + 64'h60, 1'b0, 1'b1, 1'b0);
    step(1'b1, BASE + 64'h24, 1'b0, 1'b0, 1'b0);
    idle(4);

    step(1'b1, BASE + 64'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, BASE + 64'h34, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'd0,         1'b0, 1'b0, 1'b1);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
    end

    idle(6);
    check("undelivered", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22041071_imem_rsp.md
YSYX_22041071_IMEM_RSP -- requirements
Module: ysyx_22041071_IMEM_RSP

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning response FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter FIFO_AW, default 1, meaning FIFO pointer width (log2 DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  `ysyx_22041071_ADDR_BUS  byte address of the instruction.
REQ-008 flush  input  1  discard in-flight and queued responses (branch redirect).
REQ-009 resp_valid  output  1  response at FIFO head.
REQ-010 resp_ready  input  1  consumer takes the response.
REQ-011 resp_pc  output  `ysyx_22041071_ADDR_BUS  address of the returned instruction.
REQ-012 resp_ins  output  `ysyx_22041071_INS_BUS  32-bit instruction word.
REQ-013 resp_err  output  1  address misaligned or below `START_ADDR.

Function
REQ-014 Request accept = req_valid & req_ready; response accept = resp_valid & resp_ready.
REQ-015 req_ready SHALL be 1 iff flush=0 and (FIFO count + in-flight flag) < DEPTH.
REQ-016 Accepted request SHALL latch req_addr into a one-entry stage register and set the in-flight flag.
REQ-017 One cycle after acceptance, the in-flight entry SHALL write into the FIFO tail (pc, ins, err); in-flight clears unless a new request is accepted in the same cycle.
REQ-018 Memory index SHALL be (addr - `START_ADDR) >> 3, read from the in-flight address; 64-bit doubleword returned.
REQ-019 ins SHALL be doubleword[63:32] when addr[2]=1, else [31:0].
REQ-020 err SHALL be 1 when addr[1:0] != 0 or addr < `START_ADDR; then ins SHALL be 32'h0 and no memory index is generated from that address (index forced 0).
REQ-021 Minimum latency: request accepted cycle N -> resp_valid cycle N+2 (stage at N+1, FIFO head visible N+2); throughput one per cycle when resp_ready stays 1.
REQ-022 Responses SHALL return in request order.
REQ-023 Simultaneous FIFO write and read SHALL keep count unchanged; read from empty or write to full SHALL never occur (guaranteed by REQ-015).
REQ-024 FIFO pointers wrap modulo DEPTH; count width FIFO_AW+1.
REQ-025 flush=1 SHALL, at that edge, clear in-flight flag, FIFO count and pointers; resp_valid=0 the next cycle; a response-accept coinciding with flush is consumed, no further response from pre-flush requests.
REQ-026 resp_pc/resp_ins/resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-027 Memory write port SHALL be tied off (wen=0, wmask=0, wdata=0).

Reset
REQ-028 reset SHALL clear in-flight flag, FIFO pointers and count; resp_valid=0, req_ready=1 in the first cycle after reset deasserts.
REQ-029 Data registers (stage addr, FIFO payload) need no reset; resp_pc/ins/err are don't-care while resp_valid=0.
REQ-030 reset asserted mid-operation SHALL drop all pending responses, identical to flush.

Structure
REQ-031 ADDR_BUS, INS_BUS, START_ADDR SHALL come from the shared define.v header.
REQ-032 FIFO SHALL be a sub-module ysyx_22041071_RSP_FIFO (DEPTH-parameterized, push/pop/flush, count).
REQ-033 Memory SHALL be one RAMHelper instance, en=1.

Verification
REQ-034 Reset then req_addr=0x8000_0000 held valid, resp_ready=1 -> resp_valid at cycle+2, resp_pc=0x8000_0000, resp_ins=mem dword0[31:0], err=0.
REQ-035 Back-to-back 0x8000_0000,0x8000_0004,0x8000_0008 -> three responses on consecutive cycles, 0x8000_0004 returns dword0[63:32].
REQ-036 resp_ready=0 for 5 cycles with req_valid=1 -> exactly 2 accepted, req_ready=0 afterwards, head data stable; release -> both drain in order.
REQ-037 req_addr=0x8000_0002 and 0x7FFF_FFFC -> resp_err=1, resp_ins=0 for each.
REQ-038 FIFO full, flush pulse -> next cycle resp_valid=0, req_ready=1; next request's response is the only one returned.
REQ-039 reset asserted with one in-flight and one queued -> no response after reset, req_ready=1.
